// File: rtl/mouse_position_tracker_pkg.sv
// Shared constants for the mouse position tracker.
// Status bit positions, event width and axis mode codes.
package mouse_pkg;
  localparam int ST_YOVF   = 7;
  localparam int ST_XOVF   = 6;
  localparam int ST_YSGN   = 5;
  localparam int ST_XSGN   = 4;
  localparam int ST_BTN_HI = 2;
  localparam int ST_BTN_LO = 0;

  localparam int EVT_W = 6;

  localparam logic MODE_CLAMP = 1'b0;
  localparam logic MODE_WRAP  = 1'b1;
endpackage

// File: rtl/mouse_position_tracker_if.sv
// Packet input bus and button-event FIFO bus.
// master drives the bus, slave consumes it.
interface mouse_pkt_if;
  logic       PKT_VALID;
  logic [7:0] PKT_STATUS;
  logic [7:0] PKT_DX;
  logic [7:0] PKT_DY;
  logic [7:0] PKT_DZ;
  logic [1:0] SPEED_SHIFT;

  modport master (
    output PKT_VALID, PKT_STATUS, PKT_DX,
    output PKT_DY, PKT_DZ, SPEED_SHIFT
  );
  modport slave (
    input PKT_VALID, PKT_STATUS, PKT_DX,
    input PKT_DY, PKT_DZ, SPEED_SHIFT
  );
endinterface

interface mouse_evt_if;
  import mouse_pkg::*;
  logic             EVT_VALID;
  logic [EVT_W-1:0] EVT_DATA;
  logic             EVT_ACK;
  logic             EVT_OVERFLOW;

  modport master (
    output EVT_VALID, EVT_DATA, EVT_OVERFLOW,
    input  EVT_ACK
  );
  modport slave (
    input  EVT_VALID, EVT_DATA, EVT_OVERFLOW,
    output EVT_ACK
  );
endinterface

// File: rtl/mouse_position_tracker_evt_fifo.sv
// Button-event FIFO: DEPTH (power of two) x WIDTH.
// Ports: clk/rst, push/push_data, pop, data, empty/full/last.
module mouse_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             empty,
  output logic             full,
  output logic             last
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr;
  logic [AW-1:0]    rd;
  logic [AW:0]      cnt;
  logic             do_pop;
  logic             do_push;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign last  = (cnt == (AW+1)'(1));
  assign data  = mem[rd];

  // A pop frees the slot the same cycle, so a full FIFO can still accept.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop)  rd <= rd + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/mouse_position_tracker.sv
// PS/2 mouse tracker: 2-stage delta/position pipeline + button FIFO.
// Ports: CLK, RESET, pkt (packet bus), evt (event bus), POS_*, BUTTONS, UPDATE.
module mouse_position_tracker
  import mouse_pkg::*;
#(
  parameter int COORD_W    = 10,
  parameter int LIMIT_X    = 640,
  parameter int LIMIT_Y    = 480,
  parameter int LIMIT_S    = 256,
  parameter bit WRAP_X     = 1'b0,
  parameter bit WRAP_Y     = 1'b0,
  parameter bit WRAP_S     = 1'b1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  mouse_pkt_if.slave         pkt,
  mouse_evt_if.master        evt,
  output logic [COORD_W-1:0] POS_X,
  output logic [COORD_W-1:0] POS_Y,
  output logic [COORD_W-1:0] POS_S,
  output logic [2:0]         BUTTONS,
  output logic               UPDATE
);
  localparam int W = COORD_W + 4;
  typedef logic signed [W-1:0] sw_t;

  if (COORD_W < 8 ||
      LIMIT_X > (1 << COORD_W) ||
      LIMIT_Y > (1 << COORD_W) ||
      LIMIT_S > (1 << COORD_W) ||
      FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("mouse_position_tracker: bad parameters");
  end

  // Overflowed axis saturates to the 9-bit extreme in its sign direction.
  function automatic sw_t raw_delta(
    input logic [7:0] raw,
    input logic       sgn,
    input logic       ovf
  );
    sw_t d;
    if (ovf) d = sgn ? sw_t'(-256) : sw_t'(255);
    else     d = sw_t'(signed'({sgn, raw}));
    return d;
  endfunction

  function automatic logic [COORD_W-1:0] step(
    input logic [COORD_W-1:0] cur,
    input sw_t                d,
    input int                 lim,
    input logic               mode
  );
    sw_t l, lm1, dd, n;
    l   = sw_t'(lim);
    lm1 = sw_t'(lim - 1);
    dd  = d;
    n   = '0;
    if (mode == MODE_CLAMP) begin
      n = sw_t'({4'b0000, cur}) + d;
      if (n[W-1])        n = '0;
      else if (n > lm1)  n = lm1;
    end else begin
      // One fold is enough once |delta| < limit.
      if (dd > lm1)       dd = lm1;
      else if (dd < -lm1) dd = -lm1;
      n = sw_t'({4'b0000, cur}) + dd;
      if (n[W-1])        n = n + l;
      else if (n >= l)   n = n - l;
    end
    return n[COORD_W-1:0];
  endfunction

  logic                  s1_valid;
  sw_t                   s1_dx;
  sw_t                   s1_dy;
  sw_t                   s1_dz;
  logic [2:0]            s1_btn;
  logic [COORD_W-1:0]    nx, ny, ns;
  logic                  evt_push;
  logic [EVT_W-1:0]      evt_word;
  logic                  pop;
  logic                  f_empty, f_full, f_last;
  logic                  ovf;
  logic                  unused_ok;

  assign unused_ok = ^{pkt.PKT_STATUS[3], pkt.PKT_DZ[7:4]};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= pkt.PKT_VALID;
      if (pkt.PKT_VALID) begin
        s1_dx  <= raw_delta(pkt.PKT_DX,
                            pkt.PKT_STATUS[ST_XSGN],
                            pkt.PKT_STATUS[ST_XOVF])
                  <<< pkt.SPEED_SHIFT;
        s1_dy  <= raw_delta(pkt.PKT_DY,
                            pkt.PKT_STATUS[ST_YSGN],
                            pkt.PKT_STATUS[ST_YOVF])
                  <<< pkt.SPEED_SHIFT;
        s1_dz  <= sw_t'(signed'(pkt.PKT_DZ[3:0]));
        s1_btn <= pkt.PKT_STATUS[ST_BTN_HI:ST_BTN_LO];
      end
    end
  end

  // Stage 2 reads the committed positions, so back-to-back packets chain.
  always_comb begin
    nx = step(POS_X, s1_dx, LIMIT_X, WRAP_X);
    ny = step(POS_Y, s1_dy, LIMIT_Y, WRAP_Y);
    ns = step(POS_S, s1_dz, LIMIT_S, WRAP_S);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      POS_X   <= COORD_W'(LIMIT_X / 2);
      POS_Y   <= COORD_W'(LIMIT_Y / 2);
      POS_S   <= COORD_W'(LIMIT_S / 2);
      BUTTONS <= '0;
      UPDATE  <= 1'b0;
    end else begin
      UPDATE <= s1_valid;
      if (s1_valid) begin
        POS_X   <= nx;
        POS_Y   <= ny;
        POS_S   <= ns;
        BUTTONS <= s1_btn;
      end
    end
  end

  assign evt_push = s1_valid && (s1_btn != BUTTONS);
  assign evt_word = {s1_btn & ~BUTTONS, BUTTONS & ~s1_btn};
  assign pop      = evt.EVT_ACK && !f_empty;

  mouse_evt_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EVT_W)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RESET),
    .push     (evt_push),
    .push_data(evt_word),
    .pop      (pop),
    .data     (evt.EVT_DATA),
    .empty    (f_empty),
    .full     (f_full),
    .last     (f_last)
  );

  // Sticky drop flag; cleared only when the queue is drained.
  always_ff @(posedge CLK) begin
    if (RESET)
      ovf <= 1'b0;
    else if (evt_push && f_full && !pop)
      ovf <= 1'b1;
    else if (pop && f_last && !evt_push)
      ovf <= 1'b0;
  end

  assign evt.EVT_VALID    = !f_empty;
  assign evt.EVT_OVERFLOW = ovf;
endmodule

// File: tb/tb_mouse_position_tracker.sv
// Self-checking bench: clamp/wrap DUT pair vs behavioural model.
// Directed corner cases followed by random packets, acks and resets.
module tb_mouse_position_tracker;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  mouse_pkt_if pkt();
  mouse_evt_if evt0();
  mouse_evt_if evt1();

  logic [9:0] px0, py0, ps0, px1, py1, ps1;
  logic [2:0] b0, b1;
  logic       u0, u1;

  mouse_position_tracker dut0 (
    .CLK(CLK), .RESET(RESET), .pkt(pkt), .evt(evt0),
    .POS_X(px0), .POS_Y(py0), .POS_S(ps0),
    .BUTTONS(b0), .UPDATE(u0)
  );

  mouse_position_tracker #(
    .WRAP_X(1'b1), .WRAP_Y(1'b1), .WRAP_S(1'b0)
  ) dut1 (
    .CLK(CLK), .RESET(RESET), .pkt(pkt), .evt(evt1),
    .POS_X(px1), .POS_Y(py1), .POS_S(ps1),
    .BUTTONS(b1), .UPDATE(u1)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int         due;
    logic [7:0] st;
    logic [7:0] dx;
    logic [7:0] dy;
    logic [7:0] dz;
    logic [1:0] sh;
  } pend_t;

  pend_t pend[$];
  int    q[$];
  int    mx[2], my[2], ms[2];
  int    mb, upd, movf, ecount;
  bit    ready = 0;
  bit    wx[2] = '{1'b0, 1'b1};
  bit    wy[2] = '{1'b0, 1'b1};
  bit    ws[2] = '{1'b1, 1'b0};

  function automatic int dxy(input logic [7:0] raw, input bit sgn,
                             input bit ovf, input logic [1:0] sh);
    int b;
    if (ovf) b = sgn ? -256 : 255;
    else     b = sgn ? int'(raw) - 256 : int'(raw);
    return b * (1 << sh);
  endfunction

  function automatic int dzv(input logic [7:0] raw);
    logic [3:0] lo;
    lo = raw[3:0];
    return int'(lo) - (lo[3] ? 16 : 0);
  endfunction

  function automatic int axis(input int pos, input int d,
                              input int lim, input bit wrap);
    int n, dd;
    if (!wrap) begin
      n = pos + d;
      if (n < 0) n = 0;
      if (n > lim - 1) n = lim - 1;
    end else begin
      dd = d;
      if (dd > lim - 1) dd = lim - 1;
      if (dd < -(lim - 1)) dd = -(lim - 1);
      n = pos + dd;
      if (n < 0) n = n + lim;
      else if (n >= lim) n = n - lim;
    end
    return n;
  endfunction

  task automatic model_step();
    pend_t p;
    bit pop, push;
    int ev, nb;
    ecount++;
    if (RESET) begin
      mx = '{320, 320};
      my = '{240, 240};
      ms = '{128, 128};
      mb = 0; upd = 0; movf = 0;
      q.delete();
      pend.delete();
      ready = 1;
      return;
    end
    upd = 0; push = 0; ev = 0;
    pop = evt0.EVT_ACK && q.size() > 0;
    if (pend.size() > 0 && pend[0].due == ecount) begin
      p = pend.pop_front();
      for (int i = 0; i < 2; i++) begin
        mx[i] = axis(mx[i], dxy(p.dx, p.st[4], p.st[6], p.sh), 640, wx[i]);
        my[i] = axis(my[i], dxy(p.dy, p.st[5], p.st[7], p.sh), 480, wy[i]);
        ms[i] = axis(ms[i], dzv(p.dz), 256, ws[i]);
      end
      nb = int'(p.st[2:0]);
      if (nb != mb) begin
        push = 1;
        ev = ((nb & ~mb) << 3) | (mb & ~nb);
      end
      mb = nb;
      upd = 1;
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < 4) q.push_back(ev);
      else movf = 1;
    end
    if (pop && q.size() == 0) movf = 0;
    if (pkt.PKT_VALID) begin
      p.due = ecount + 1;
      p.st = pkt.PKT_STATUS;
      p.dx = pkt.PKT_DX;
      p.dy = pkt.PKT_DY;
      p.dz = pkt.PKT_DZ;
      p.sh = pkt.SPEED_SHIFT;
      pend.push_back(p);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge CLK);
    if (ready) begin
      chk("d0 pos_x", int'(px0), mx[0]);
      chk("d0 pos_y", int'(py0), my[0]);
      chk("d0 pos_s", int'(ps0), ms[0]);
      chk("d1 pos_x", int'(px1), mx[1]);
      chk("d1 pos_y", int'(py1), my[1]);
      chk("d1 pos_s", int'(ps1), ms[1]);
      chk("d0 buttons", int'(b0), mb);
      chk("d1 buttons", int'(b1), mb);
      chk("d0 update", int'(u0), upd);
      chk("d1 update", int'(u1), upd);
      chk("d0 evt_valid", int'(evt0.EVT_VALID), int'(q.size() > 0));
      chk("d1 evt_valid", int'(evt1.EVT_VALID), int'(q.size() > 0));
      chk("d0 evt_ovf", int'(evt0.EVT_OVERFLOW), movf);
      chk("d1 evt_ovf", int'(evt1.EVT_OVERFLOW), movf);
      if (q.size() > 0) begin
        chk("d0 evt_data", int'(evt0.EVT_DATA), q[0]);
        chk("d1 evt_data", int'(evt1.EVT_DATA), q[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_ack(input logic a);
    evt0.EVT_ACK = a;
    evt1.EVT_ACK = a;
  endtask

  task automatic send(input logic [7:0] st, input logic [7:0] dx,
                      input logic [7:0] dy, input logic [7:0] dz,
                      input logic [1:0] sh);
    pkt.PKT_VALID   = 1'b1;
    pkt.PKT_STATUS  = st;
    pkt.PKT_DX      = dx;
    pkt.PKT_DY      = dy;
    pkt.PKT_DZ      = dz;
    pkt.SPEED_SHIFT = sh;
    @(negedge CLK);
    pkt.PKT_VALID = 1'b0;
  endtask

  task automatic ack_pulse();
    set_ack(1'b1);
    @(negedge CLK);
    set_ack(1'b0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    pkt.PKT_VALID = 1'b0;
    pkt.PKT_STATUS = '0;
    pkt.PKT_DX = '0;
    pkt.PKT_DY = '0;
    pkt.PKT_DZ = '0;
    pkt.SPEED_SHIFT = '0;
    set_ack(1'b0);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    chk("rst pos_x", int'(px0), 320);
    chk("rst pos_y", int'(py0), 240);
    chk("rst pos_s", int'(ps0), 128);
    chk("rst buttons", int'(b0), 0);
    chk("rst evt_valid", int'(evt0.EVT_VALID), 0);

    // +16 in X: visible two cycles after the strobe, single pulse
    send(8'h00, 8'h10, 8'h00, 8'h00, 2'd0);
    chk("lat pos_x early", int'(px0), 320);
    @(negedge CLK);
    chk("basic pos_x", int'(px0), 336);
    chk("basic pos_y", int'(py0), 240);
    chk("basic update", int'(u0), 1);
    @(negedge CLK);
    chk("basic update off", int'(u0), 0);

    // walk X to 5, then -16: clamp -> 0, wrap -> 629
    do_reset();
    send(8'h10, 8'h00, 8'h00, 8'h00, 2'd0);
    send(8'h10, 8'hC5, 8'h00, 8'h00, 2'd0);
    @(negedge CLK);
    chk("walk pos_x", int'(px0), 5);
    send(8'h10, 8'hF0, 8'h00, 8'h00, 2'd0);
    @(negedge CLK);
    chk("clamp low x", int'(px0), 0);
    chk("wrap low x", int'(px1), 629);

    // X overflow positive, gain 8: delta 2040
    do_reset();
    send(8'h40, 8'h00, 8'h00, 8'h00, 2'd3);
    @(negedge CLK);
    chk("ovf clamp x", int'(px0), 639);
    chk("ovf wrap x", int'(px1), 319);

    // scroll wrap both directions
    do_reset();
    for (int i = 0; i < 18; i++) send(8'h00, 8'h00, 8'h00, 8'h07, 2'd0);
    send(8'h00, 8'h00, 8'h00, 8'h01, 2'd0);
    @(negedge CLK);
    chk("scroll top", int'(ps0), 255);
    send(8'h00, 8'h00, 8'h00, 8'h01, 2'd0);
    @(negedge CLK);
    chk("scroll wrap up", int'(ps0), 0);
    send(8'h00, 8'h00, 8'h00, 8'h0F, 2'd0);
    @(negedge CLK);
    chk("scroll wrap dn", int'(ps0), 255);

    // button events: press L, drain, then five changes into depth 4
    do_reset();
    send(8'h01, 8'h00, 8'h00, 8'h00, 2'd0);
    @(negedge CLK);
    chk("L press evt", int'(evt0.EVT_DATA), 6'b001000);
    ack_pulse();
    send(8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
    send(8'h02, 8'h00, 8'h00, 8'h00, 2'd0);
    send(8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
    send(8'h04, 8'h00, 8'h00, 8'h00, 2'd0);
    send(8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
    @(negedge CLK);
    chk("fifo full valid", int'(evt0.EVT_VALID), 1);
    chk("fifo overflow", int'(evt0.EVT_OVERFLOW), 1);
    chk("fifo head", int'(evt0.EVT_DATA), 6'b000001);
    repeat (3) ack_pulse();
    chk("ovf held", int'(evt0.EVT_OVERFLOW), 1);
    ack_pulse();
    chk("drained valid", int'(evt0.EVT_VALID), 0);
    chk("drained ovf", int'(evt0.EVT_OVERFLOW), 0);

    // reset kills in-flight packets
    do_reset();
    pkt.PKT_VALID = 1'b1;
    pkt.PKT_STATUS = 8'h00;
    pkt.PKT_DX = 8'h01;
    @(negedge CLK);
    pkt.PKT_DX = 8'h02;
    @(negedge CLK);
    pkt.PKT_VALID = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("flush pos_x", int'(px0), 320);
    @(negedge CLK);
    chk("flush pos_x 2", int'(px0), 320);
    chk("flush update", int'(u0), 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      RESET = ($urandom_range(0, 149) == 0);
      pkt.PKT_VALID = $urandom_range(0, 1) == 1;
      pkt.PKT_STATUS = 8'($urandom);
      pkt.PKT_DX = 8'($urandom);
      pkt.PKT_DY = 8'($urandom);
      pkt.PKT_DZ = 8'($urandom);
      pkt.SPEED_SHIFT = 2'($urandom);
      set_ack($urandom_range(0, 3) == 0);
      @(negedge CLK);
    end
    RESET = 1'b0;
    pkt.PKT_VALID = 1'b0;
    set_ack(1'b0);
    repeat (5) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
